// File: rtl/apb_completer_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_completer_regs
// Description : APB4 completer with a bank of 32-bit registers. Register 0 is
//               a read-only ID word. Transfers take WAIT_CYCLES wait states.
//               Misaligned, out-of-range, read-only-write and protocol
//               violations are answered with pslverr.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_completer_regs #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SW    = DATA_WIDTH / 8;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_err    = 2'd2;
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [3:0]            r_wcnt;
  logic                  r_err;
  logic                  r_write;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [ADDR_WIDTH-3:0] w_word;
  logic [IDX_W-1:0]      w_setup_idx;
  logic                  w_setup;
  logic                  w_access;
  logic                  w_complete;
  logic                  w_commit;
  logic                  w_setup_err;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_rd_word [NUM_REGS];

  // Full word index is decoded so high address bits never alias onto the bank
  assign w_word      = paddr[ADDR_WIDTH-1:2];
  assign w_setup_idx = w_word[IDX_W-1:0];
  assign w_setup     = (r_state == c_st_idle) && psel && !penable;
  assign w_access    = psel && penable;
  assign w_complete  = (r_state == c_st_access) && w_access && (r_wcnt == 4'd0);
  assign w_commit    = w_complete && r_write && !r_err;
  assign w_setup_err = (paddr[1:0] != 2'b00)
                     || (w_word >= (ADDR_WIDTH-2)'(NUM_REGS))
                     || (pwrite && (w_word == '0));
  assign w_rd_data   = w_setup_err ? '0 : w_rd_word[w_setup_idx];

  // Register bank: word 0 is the constant ID, the rest are byte-writable
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
    if (gi == 0) begin : g_id
      assign w_rd_word[gi] = ID_VALUE;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_reg;
      // Byte-strobed update from the latched setup data on the completing edge
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          r_reg <= '0;
        end else if (w_commit && (r_idx == IDX_W'(gi))) begin
          for (int b = 0; b < SW; b++) begin
            if (r_strb[b]) r_reg[8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
      assign w_rd_word[gi] = r_reg;
    end
  end

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= c_st_idle;
    else          r_state <= w_next_state;
  end

  // Next-state logic; early deassertion in ACCESS takes priority over completion
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (psel && penable) w_next_state = c_st_err;
        else if (psel)       w_next_state = c_st_access;
      end
      c_st_access: begin
        if (!w_access)              w_next_state = c_st_err;
        else if (r_wcnt == 4'd0)    w_next_state = c_st_idle;
      end
      c_st_err:    w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  // Output logic: response driven purely from registered state
  always_comb begin
    pready  = ((r_state == c_st_access) && (r_wcnt == 4'd0)) || (r_state == c_st_err);
    pslverr = pready && ((r_state == c_st_err) || r_err);
  end

  // Setup-phase capture, wait-state countdown and read-data load
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wcnt   <= 4'd0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_prdata <= '0;
    end else if (w_setup) begin
      r_wcnt  <= c_wait_load;
      r_err   <= w_setup_err;
      r_write <= pwrite;
      r_idx   <= w_setup_idx;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
      if (!pwrite) r_prdata <= w_rd_data;
    end else if ((r_state == c_st_access) && w_access && (r_wcnt != 4'd0)) begin
      r_wcnt <= r_wcnt - 4'd1;
    end
  end

  assign prdata = r_prdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_completer_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_completer_regs
// Description : Self-checking bench for apb_completer_regs. One instance with
//               two wait states and one with zero wait states share the bus;
//               dsel steers psel to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_completer_regs;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel_bus, penable, pwrite, dsel;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic        psel_a, psel_b;
  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  assign psel_a    = psel_bus & ~dsel;
  assign psel_b    = psel_bus &  dsel;
  assign prdata_m  = dsel ? prdata_b  : prdata_a;
  assign pready_m  = dsel ? pready_b  : pready_a;
  assign pslverr_m = dsel ? pslverr_b : pslverr_a;

  apb_completer_regs #(.WAIT_CYCLES(2)) u_dut_w2 (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_completer_regs #(.WAIT_CYCLES(0)) u_dut_w0 (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  typedef struct {
    logic        dut;      // 0 = two wait states, 1 = zero wait states
    logic        b2b;      // 1 = start directly after the previous transfer
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;  // access cycles up to and including pready
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic go_idle();
    psel_bus = 1'b0;
    penable  = 1'b0;
    tick();
  endtask

  // Full transfer; live bus is scrambled during ACCESS to expose use of live data
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err,
                      output int cyc, output logic early_err);
    logic done;
    psel_bus = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wdata;
    pstrb    = strb;
    tick();
    penable  = 1'b1;
    paddr    = addr ^ 32'h4;
    pwdata   = ~wdata;
    pstrb    = ~strb;
    cyc = 0; done = 1'b0; rd = '0; err = 1'b0; early_err = 1'b0;
    while (!done && cyc < 20) begin
      cyc++;
      if (pready_m) begin
        rd   = prdata_m;
        err  = pslverr_m;
        done = 1'b1;
      end else begin
        if (pslverr_m) early_err = 1'b1;
      end
      tick();
    end
    if (!done) cyc = 99;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, early;
    int          cyc;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 1'b0, 32'h0,          1'b0, 3};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0, 3};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0,          1'b0, 3};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 1'b1, 32'h12BB_56DD, 1'b0, 3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'hA9B0_0001, 1'b0, 3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h0,         4'h0, 1'b1, 32'h0,          1'b1, 3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 32'h0,          1'b1, 3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,          1'b1, 3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'hA9B0_0001, 1'b0, 3};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h5555_5555, 4'h0, 1'b0, 32'h0,          1'b0, 3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'h0,          1'b0, 3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h1000_0004, 32'h0,         4'h0, 1'b1, 32'h0,          1'b1, 3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0000_003C, 32'h0,         4'h0, 1'b1, 32'h0,          1'b0, 3};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0000_003C, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,          1'b0, 3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0000_003C, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,          1'b0, 1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1};

    presetn = 1'b0; psel_bus = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; dsel = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset prdata w2",  prdata_a,  32'h0);
    chk("reset pready w2",  {31'b0, pready_a},  32'h0);
    chk("reset pslverr w2", {31'b0, pslverr_a}, 32'h0);
    chk("reset prdata w0",  prdata_b,  32'h0);
    chk("reset pready w0",  {31'b0, pready_b},  32'h0);
    chk("reset pslverr w0", {31'b0, pslverr_b}, 32'h0);
    presetn = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      if (!vecs[i].b2b) begin
        go_idle();
        dsel = vecs[i].dut;
      end
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, cyc, early);
      chk($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d pslverr before pready", i), {31'b0, early}, 32'h0);
      if (vecs[i].chk_rd) chk($sformatf("v%0d prdata", i), rd, vecs[i].exp_rd);
    end

    // Early psel drop during the second access cycle of a write
    go_idle();
    dsel = 1'b0;
    psel_bus = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    chk("abort acc1 pready", {31'b0, pready_m}, 32'h0);
    tick();
    chk("abort acc2 pready", {31'b0, pready_m}, 32'h0);
    psel_bus = 1'b0; penable = 1'b0;
    tick();
    chk("abort err pready",  {31'b0, pready_m},  32'h1);
    chk("abort err pslverr", {31'b0, pslverr_m}, 32'h1);
    tick();
    chk("abort idle pready", {31'b0, pready_m}, 32'h0);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc, early);
    chk("abort readback", rd, 32'h12BB_56DD);
    chk("abort readback err", {31'b0, err}, 32'h0);

    // Access phase without a setup phase on the zero-wait instance
    go_idle();
    dsel = 1'b1;
    psel_bus = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
    tick();
    chk("nosetup pready",  {31'b0, pready_m},  32'h1);
    chk("nosetup pslverr", {31'b0, pslverr_m}, 32'h1);
    psel_bus = 1'b0; penable = 1'b0;
    tick();
    chk("nosetup idle pready", {31'b0, pready_m}, 32'h0);

    // Asynchronous reset in the completing access cycle of a write
    go_idle();
    dsel = 1'b0;
    psel_bus = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'hC; pwdata = 32'h1111_2222; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    tick();
    chk("rst pre pready", {31'b0, pready_m}, 32'h1);
    presetn = 1'b0;
    #1;
    chk("rst async pready",  {31'b0, pready_m},  32'h0);
    chk("rst async pslverr", {31'b0, pslverr_m}, 32'h0);
    chk("rst async prdata",  prdata_m, 32'h0);
    psel_bus = 1'b0; penable = 1'b0;
    @(posedge pclk);
    tick();
    presetn = 1'b1;
    tick();
    xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, err, cyc, early);
    chk("rst 0xC readback", rd, 32'h0);
    chk("rst 0xC cycles", 32'(cyc), 32'd3);
    go_idle();
    xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc, early);
    chk("rst 0x4 cleared", rd, 32'h0);
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_completer_regs.md
Name: apb_completer_regs

Overview:
APB4 completer (peripheral) that sits directly downstream of the APB bridge requester and terminates its transfers. It holds a bank of 32-bit registers and serves reads and byte-strobed writes after a programmable number of wait states. It flags misaligned, out-of-range, read-only-write and protocol-violating transfers with pslverr. It is also the device-under-test target for the bridge's read, invalid-read and write sequences.

Parameters:
ADDR_WIDTH, 32, paddr width
DATA_WIDTH, 32, pwdata/prdata width (fixed 32; pstrb is DATA_WIDTH/8)
NUM_REGS, 16, number of registers; valid word index 0..NUM_REGS-1
WAIT_CYCLES, 2, wait states inserted per transfer (0..15); 0 gives a zero-wait transfer
ID_VALUE, 32'hA9B0_0001, read-only contents of register 0

Ports:
pclk  in  1  APB clock; the block's only clock
presetn  in  1  asynchronous active-low reset
psel  in  1  select
penable  in  1  access-phase enable
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte strobes
prdata  out  DATA_WIDTH  read data
pready  out  1  transfer-complete / wait-state control
pslverr  out  1  error response, valid only while pready=1

Behaviour:
- Interface: one clock, pclk; reset presetn is asynchronous and active-low.
- Reset: state=IDLE, wcnt=0, err=0, all registers 0 (register 0 still reads ID_VALUE), prdata=0, pready=0, pslverr=0. Asserting reset mid-transfer aborts it with no write committed.
- FSM states: IDLE, ACCESS, ERR.
- IDLE, psel=1 and penable=0 (setup phase): at the edge, latch paddr, pwrite, pwdata and pstrb; load wcnt=WAIT_CYCLES; compute err; go to ACCESS.
  - err=1 if paddr[1:0]!=0.
  - err=1 if paddr[ADDR_WIDTH-1:2] >= NUM_REGS.
  - err=1 if pwrite=1 and the word index is 0.
- IDLE, psel=1 and penable=1 (access with no setup): go to ERR.
- ACCESS, psel=1 and penable=1 at the edge:
  - wcnt!=0: decrement wcnt.
  - wcnt=0: transfer completes; go to IDLE.
- ACCESS, psel=0 or penable=0 at the edge (early deassertion): go to ERR, nothing committed. This rule wins over completion.
- ERR: lasts exactly one cycle, then IDLE; inputs are ignored.
- pready is combinational from registered state: pready = (ACCESS and wcnt==0) or ERR. Transfer latency is WAIT_CYCLES+1 access-phase cycles.
- pslverr = pready and (ERR or err). It is 0 whenever pready=0.
- Read data:
  - Loaded into prdata at the IDLE->ACCESS edge: register contents, or 0 when err=1.
  - prdata holds its value until the next read setup. Writes and ERR leave prdata unchanged.
- Write commit:
  - Happens on the completing edge only, and only if err=0.
  - Byte i of the register is updated iff pstrb[i]=1. pstrb=0 is a legal no-op with pslverr=0.
  - The latched pwdata/pstrb are used, not the live bus values.
- Back-to-back: after completion the FSM is in IDLE. A setup phase in that cycle starts the next transfer with no idle gap, so transfers take WAIT_CYCLES+2 cycles each.
- Address bits above the word index are decoded (no aliasing). paddr/pwdata changes during ACCESS are ignored.

Test Plan:
- WAIT_CYCLES=2, write 0x1234_5678 with pstrb=4'hF to 0x4, then read 0x4 -> for each transfer pready rises on the 3rd access cycle; read prdata=0x1234_5678; pslverr=0 throughout.
- Write 0xAABB_CCDD with pstrb=4'b0101 to 0x4 (holding 0x1234_5678), then read -> 0x12BB_56DD; then read 0x0 -> ID_VALUE 0xA9B0_0001.
- Read paddr=0x3; read paddr=NUM_REGS*4=0x40; write 0xFFFF_FFFF to 0x0 -> each gives pready with pslverr=1. The reads return prdata=0; register 0 still reads 0xA9B0_0001.
- Setup and access to 0x4, then drop psel in the 2nd access cycle with WAIT_CYCLES=2 -> next cycle pready=1 and pslverr=1 for one cycle, then IDLE. A write attempted this way leaves the register unchanged.
- WAIT_CYCLES=0: back-to-back write/read to 0x8 with psel held high -> pready in the first access cycle of each transfer, 2 cycles per transfer, readback matches. penable=1 in IDLE without setup -> one-cycle ERR with pslverr=1.
- Drive presetn low in the middle of the access phase of a write to 0xC -> pready, pslverr and prdata are 0 immediately (asynchronous); register 0xC reads 0 after reset releases.
